// File: rtl/and_struct.sv
// AND gate with registered copy, a sticky record of the input combinations
// seen so far, and a saturating count of the cycles in which the output was high.
module and_struct #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a,
  input  logic             b,
  output logic             f,
  output logic             f_q,
  output logic [3:0]       seen,
  output logic             all_seen,
  output logic [CNT_W-1:0] hi_cnt,
  output logic             hi_sat
);

  localparam logic [CNT_W-1:0] CntMax = '1;
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  logic [3:0]       seen_q, seen_d;
  logic [CNT_W-1:0] hi_cnt_q, hi_cnt_d;
  logic             f_d;

  // Gate-level AND; stays live during reset because nothing gates it.
  and u_and (f, a, b);

  // Next-state: mark the current {a,b} combination and bump the saturating counter.
  always_comb begin
    seen_d         = seen_q;
    seen_d[{a, b}] = 1'b1;
    hi_cnt_d       = hi_cnt_q;
    if (f && (hi_cnt_q != CntMax)) begin
      hi_cnt_d = hi_cnt_q + CntOne;
    end
    f_d = f;
  end

  // State registers with synchronous active-low reset taking priority.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      f_q      <= 1'b0;
      seen_q   <= 4'b0000;
      hi_cnt_q <= '0;
    end else begin
      f_q      <= f_d;
      seen_q   <= seen_d;
      hi_cnt_q <= hi_cnt_d;
    end
  end

  // Output decodes of the registered state, no extra latency.
  always_comb begin
    seen     = seen_q;
    hi_cnt   = hi_cnt_q;
    all_seen = (seen_q == 4'b1111);
    hi_sat   = (hi_cnt_q == CntMax);
  end

endmodule

// File: tb/tb_and_struct.sv
// Directed bench for and_struct with CNT_W = 8.
module tb_and_struct;

  logic       clk;
  logic       rst_n;
  logic       a;
  logic       b;
  logic       f;
  logic       f_q;
  logic [3:0] seen;
  logic       all_seen;
  logic [7:0] hi_cnt;
  logic       hi_sat;

  int total;
  int bad;

  and_struct #(
    .CNT_W(8)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .a       (a),
    .b       (b),
    .f       (f),
    .f_q     (f_q),
    .seen    (seen),
    .all_seen(all_seen),
    .hi_cnt  (hi_cnt),
    .hi_sat  (hi_sat)
  );

  // 10 ns clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Drive inputs on the falling edge, check f before the rising edge,
  // then return 1 ns after the rising edge so registered outputs can be sampled.
  task automatic step(input logic na, input logic nb, input logic nrst, input logic exp_f);
    @(negedge clk);
    a     = na;
    b     = nb;
    rst_n = nrst;
    #1;
    check_eq("f_comb", {31'd0, f}, {31'd0, exp_f});
    @(posedge clk);
    #1;
  endtask

  logic [3:0] f_tab;
  logic [3:0] seen_tab [4];
  logic [3:0] all_tab;
  logic [1:0] ab;

  initial begin
    total = 0;
    bad   = 0;
    a     = 1'b0;
    b     = 1'b0;
    rst_n = 1'b0;
    f_tab = 4'b1000;
    all_tab = 4'b1000;
    seen_tab[0] = 4'b0001;
    seen_tab[1] = 4'b0011;
    seen_tab[2] = 4'b0111;
    seen_tab[3] = 4'b1111;

    // Reset held while every input combination is applied: f stays live,
    // registered state stays cleared.
    for (int i = 0; i < 4; i++) begin
      ab = 2'(i);
      step(ab[1], ab[0], 1'b0, f_tab[i]);
      check_eq("rst_f_q", {31'd0, f_q}, 32'd0);
      check_eq("rst_seen", {28'd0, seen}, 32'd0);
      check_eq("rst_hi_cnt", {24'd0, hi_cnt}, 32'd0);
      check_eq("rst_all_seen", {31'd0, all_seen}, 32'd0);
      check_eq("rst_hi_sat", {31'd0, hi_sat}, 32'd0);
    end

    // Sweep 00..11; the first edge with rst_n=1 is a normal update.
    for (int i = 0; i < 4; i++) begin
      ab = 2'(i);
      step(ab[1], ab[0], 1'b1, f_tab[i]);
      check_eq("sweep_f_q", {31'd0, f_q}, {31'd0, f_tab[i]});
      check_eq("sweep_seen", {28'd0, seen}, {28'd0, seen_tab[i]});
      check_eq("sweep_all_seen", {31'd0, all_seen}, {31'd0, all_tab[i]});
    end
    check_eq("sweep_hi_cnt", {24'd0, hi_cnt}, 32'd1);

    // Fresh reset, then {a,b}=10 for 5 cycles: only seen[2], no counting.
    step(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, 1'b1, 1'b0);
      check_eq("ab10_f_q", {31'd0, f_q}, 32'd0);
      check_eq("ab10_hi_cnt", {24'd0, hi_cnt}, 32'd0);
      check_eq("ab10_seen", {28'd0, seen}, 32'h4);
    end

    // Ten cycles of 11 brings hi_cnt to 10.
    for (int i = 1; i <= 10; i++) begin
      step(1'b1, 1'b1, 1'b1, 1'b1);
      check_eq("cnt10_hi_cnt", {24'd0, hi_cnt}, 32'(i));
      check_eq("cnt10_f_q", {31'd0, f_q}, 32'd1);
    end
    check_eq("cnt10_seen", {28'd0, seen}, 32'hC);

    // One reset edge with a=b=1 beats the increment and the seen update.
    step(1'b1, 1'b1, 1'b0, 1'b1);
    check_eq("midrst_hi_cnt", {24'd0, hi_cnt}, 32'd0);
    check_eq("midrst_seen", {28'd0, seen}, 32'd0);
    check_eq("midrst_f_q", {31'd0, f_q}, 32'd0);
    check_eq("midrst_f", {31'd0, f}, 32'd1);

    // 300 cycles of 11: count to 255, saturate, never wrap.
    for (int k = 1; k <= 300; k++) begin
      step(1'b1, 1'b1, 1'b1, 1'b1);
      check_eq("sat_hi_cnt", {24'd0, hi_cnt}, (k >= 255) ? 32'd255 : 32'(k));
      check_eq("sat_hi_sat", {31'd0, hi_sat}, (k >= 255) ? 32'd1 : 32'd0);
    end

    // Saturated count holds when f drops.
    step(1'b0, 1'b1, 1'b1, 1'b0);
    check_eq("sat_hold_hi_cnt", {24'd0, hi_cnt}, 32'd255);
    check_eq("sat_hold_f_q", {31'd0, f_q}, 32'd0);
    check_eq("sat_hold_seen", {28'd0, seen}, 32'hA);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/and_struct.md
AND_STRUCT -- requirements
Module: and_struct

Interface
REQ-001 The block SHALL have parameter CNT_W, default 8: width of the high-cycle counter, legal range 2..16.
REQ-002 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-004 The block SHALL have port a, input, 1 bit: first AND operand.
REQ-005 The block SHALL have port b, input, 1 bit: second AND operand.
REQ-006 The block SHALL have port f, output, 1 bit: combinational a AND b.
REQ-007 The block SHALL have port f_q, output, 1 bit: f registered one cycle.
REQ-008 The block SHALL have port seen, output, 4 bits: sticky record of input combinations applied; bit index = {a,b}.
REQ-009 The block SHALL have port all_seen, output, 1 bit: high when seen == 4'b1111.
REQ-010 The block SHALL have port hi_cnt, output, CNT_W bits: saturating count of cycles in which f was 1.
REQ-011 The block SHALL have port hi_sat, output, 1 bit: high when hi_cnt is at its all-ones maximum.

Function
REQ-012 f SHALL be built structurally from a gate-level AND primitive (no behavioural assign/always) and SHALL be purely combinational with zero cycle latency.
REQ-013 f SHALL be 1 only for a=1, b=1; for {a,b} = 00, 01 and 10, f SHALL be 0.
REQ-014 f SHALL follow a and b at all times, including while rst_n is low (no reset gating on f).
REQ-015 On each rising clk with rst_n=1, f_q SHALL take the current value of f (latency 1 cycle).
REQ-016 On each rising clk with rst_n=1, seen[{a,b}] SHALL be set to 1; all other bits of seen SHALL hold; bits SHALL never clear except by reset.
REQ-017 all_seen SHALL be a combinational decode of the registered seen value (no extra cycle of latency).
REQ-018 On each rising clk with rst_n=1 and f=1, hi_cnt SHALL increment by 1 unless it already equals 2^CNT_W-1, in which case it SHALL hold (no wrap-around).
REQ-019 With f=0 at the clock edge, hi_cnt SHALL hold.
REQ-020 hi_sat SHALL be a combinational decode of hi_cnt == 2^CNT_W-1.
REQ-021 An X/unknown on a or b SHALL NOT be required to be handled; inputs are assumed driven 0/1.

Reset
REQ-022 On a rising clk with rst_n=0, f_q SHALL become 0, seen SHALL become 4'b0000, and hi_cnt SHALL become 0; hence all_seen=0 and hi_sat=0.
REQ-023 Reset SHALL take priority over every update in the same cycle, including an increment of hi_cnt or setting a seen bit.
REQ-024 Reset asserted mid-operation SHALL clear all registered state on the next rising edge; f SHALL remain live throughout.
REQ-025 Deassertion of rst_n SHALL take effect at the next rising edge; the first edge with rst_n=1 SHALL perform a normal update.

Verification
REQ-026 The bench SHALL cover a 2-bit counter driving {a,b} = 00,01,10,11 one per 10 ns clock, checking f = 0,0,0,1 and f_q equal to the previous cycle's f.
REQ-027 The bench SHALL cover, after reset, one full 00..11 sweep, checking seen = 0001, 0011, 0111, 1111 after successive edges and all_seen rising on the 4th edge.
REQ-028 The bench SHALL cover holding a=b=1 for 300 cycles with CNT_W=8, checking hi_cnt reaches 255, hi_sat=1, and hi_cnt stays at 255 (no wrap).
REQ-029 The bench SHALL cover driving rst_n=0 for one edge while a=b=1 and hi_cnt=10, checking hi_cnt=0, seen=0000, f_q=0 after that edge while f=1 throughout.
REQ-030 The bench SHALL cover holding {a,b}=10 for 5 cycles, checking f=0, hi_cnt unchanged, and only seen[2] set.
